fleet_shot_writer: RTL and testbench
====================================

Name: fleet_shot_writer

Overview:
- Owns the fleet damage matrix `barcos`: 5 boats, one row per boat, one bit per segment, 1 = intact segment.
- Places boats on a 5x5 board and applies shots, clearing segment bits on hits.
- Reports hit, sunk and all-sunk per operation.
- The `barcos` output drives the downstream lost-boats status register directly.

Parameters:
- NUM_BARCOS, 5, number of boats and matrix rows (max 5).
- BOARD_DIM, 5, board rows and columns; also the maximum boat length.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- place_valid  in  1  placement request.
- place_id  in  3  boat index 0..NUM_BARCOS-1.
- place_row  in  3  bow row.
- place_col  in  3  bow column.
- place_vert  in  1  1 = segments extend down rows; 0 = extend across columns.
- place_len  in  3  boat length, 1..BOARD_DIM.
- shot_valid  in  1  shot request.
- shot_row  in  3  target row.
- shot_col  in  3  target column.
- ready  out  1  idle; requests are accepted this cycle.
- done  out  1  one-cycle pulse; results are valid.
- place_err  out  1  last placement was rejected.
- hit  out  1  last shot cleared a segment.
- sunk  out  1  last shot emptied a boat row.
- sunk_id  out  3  boat sunk by the last shot.
- all_sunk  out  1  every placed boat has an all-zero row, and at least one boat is placed.
- barcos  out  [4:0][4:0]  damage matrix; `barcos[j][k]` is segment k of boat j.

Behaviour:
Reset (`rst` low, asynchronous):
- Matrix, cell map and placed mask cleared.
- `done`, `place_err`, `hit`, `sunk`, `sunk_id`, `all_sunk` = 0.
- State IDLE, `ready` = 1.
- Reset mid-operation abandons the operation with no partial writes kept.

Acceptance:
- A request is accepted on a rising edge with `valid && ready`.
- Placement has priority: if both valids are high, the shot is not accepted and the requester holds it.
- All request fields are latched at acceptance.

Cell map:
- 25 entries of {occ, id[2:0], seg[2:0]}.
- Segment index k sits at bow + k along the chosen axis.

State machine:
- IDLE:
  - `ready` = 1.
  - Placement accepted -> PCHK, idx = 0.
  - Shot accepted -> SHOT.
- PCHK (one cell per cycle):
  - Set the error and go to DONE if any of these holds: id >= NUM_BARCOS; len = 0 or len > BOARD_DIM; boat already placed; cell off-board; cell occupied.
  - On idx = len-1 with no error -> PWR, idx = 0.
  - Rejected placement modifies nothing.
- PWR (one cell per cycle):
  - Write occ = 1, id, seg = idx.
  - On the last cell: `barcos[id]` = (1<<len)-1, set placed[id] -> DONE.
  - Placement latency: done rises 2*len+1 cycles after acceptance.
- SHOT (one cycle):
  - Look up the cell.
  - If occ and `barcos[id][seg]` = 1: clear that bit and set hit.
  - Otherwise miss: no change. This includes off-board coordinates (row or col > BOARD_DIM-1).
  - -> DONE.
- DONE (one cycle):
  - `done` = 1.
  - `sunk` = hit && `barcos[id]` == 0; `sunk_id` = id when sunk, else 0.
  - -> IDLE.
  - Shot latency: done 2 cycles after acceptance.

Result flags:
- `hit`, `sunk`, `sunk_id`, `place_err` update at DONE and hold until the next DONE.
- A placement clears `hit`/`sunk`; a shot clears `place_err`.

`all_sunk`:
- Registered, recomputed every cycle from placed mask and matrix.
- 0 when no boat is placed.

Matrix rules:
- Rows of unplaced boats stay 0.
- Bits above len-1 are never set.

Optional Feature:
- Macro: REPEAT_SHOT_DETECT_EN.
- With the macro defined:
  - Adds a 25-bit shot-history register and output `repeat_shot` (1 bit, valid with done).
  - A shot at an already-targeted cell reports `repeat_shot` = 1, `hit` = 0, `sunk` = 0, and leaves matrix and history unchanged.
  - History is cleared by reset.
- Without the macro: no port and no register; a repeat shot at a hit cell reports a miss.

Decomposition:
- battleship_pkg holds:
  - constants NUM_BARCOS_MAX = 5, BOARD_DIM = 5, NO_BOAT = 3'd7;
  - typedef cell_t {occ, id, seg};
  - typedef enum state_t {IDLE, PCHK, PWR, SHOT, DONE};
  - typedef fleet_t = logic [4:0][4:0].
- Sub-module fleet_cell_map: 25-entry cell_t storage with one combinational read port, one synchronous write port, and asynchronous clear on reset.

Test Plan:
1. Reset, then place id 0 at (1,1), horizontal, len 3 -> done at acceptance+7; `barcos[0]` = 5'b00111; `place_err` = 0.
2. After 1, place id 1 at (1,2), vertical, len 2 (overlap at (1,2)) -> `place_err` = 1; `barcos[1]` = 0; cell map unchanged.
3. After 1, shots (1,1), (1,2), (1,3) -> `hit` = 1 each; `sunk` = 0, 0, 1; `sunk_id` = 0; `all_sunk` = 1 the cycle after the last DONE.
4. Shot at (4,4) on an empty cell and shot at (7,0) off-board -> `hit` = 0; matrix unchanged; done at acceptance+2.
5. `place_valid` and `shot_valid` asserted together -> only the placement is accepted; shot accepted on the next IDLE cycle.
6. Reset asserted during PWR of a len-4 placement -> matrix all 0; cell map empty; `ready` = 1 after release; REPEAT_SHOT_DETECT_EN build: a second shot at (1,1) -> `repeat_shot` = 1, `hit` = 0.

Source files
------------

// File: rtl/battleship_pkg.sv
// Shared types and constants for the fleet damage matrix and its board cell map.
package battleship_pkg;
  localparam int NUM_BARCOS_MAX = 5;
  localparam int BOARD_DIM      = 5;
  localparam int NUM_CELLS      = 25;
  localparam logic [2:0] NO_BOAT = 3'd7;

  typedef struct packed {
    logic       occ;
    logic [2:0] id;
    logic [2:0] seg;
  } cell_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PCHK = 3'd1,
    PWR  = 3'd2,
    SHOT = 3'd3,
    DONE = 3'd4
  } state_t;

  typedef logic [4:0][4:0] fleet_t;

  // Intact-row pattern for a freshly placed boat of the given length.
  function automatic logic [4:0] len_mask(input logic [2:0] len);
    case (len)
      3'd1:    len_mask = 5'b00001;
      3'd2:    len_mask = 5'b00011;
      3'd3:    len_mask = 5'b00111;
      3'd4:    len_mask = 5'b01111;
      3'd5:    len_mask = 5'b11111;
      default: len_mask = 5'b00000;
    endcase
  endfunction
endpackage

// File: rtl/fleet_shot_writer_if.sv
// Request/result bundle between a requester and fleet_shot_writer.
// repeat_shot exists only when REPEAT_SHOT_DETECT_EN is defined.
interface fleet_shot_writer_if;
  import battleship_pkg::*;

  logic       place_valid;
  logic [2:0] place_id;
  logic [2:0] place_row;
  logic [2:0] place_col;
  logic       place_vert;
  logic [2:0] place_len;
  logic       shot_valid;
  logic [2:0] shot_row;
  logic [2:0] shot_col;
  logic       ready;
  logic       done;
  logic       place_err;
  logic       hit;
  logic       sunk;
  logic [2:0] sunk_id;
  logic       all_sunk;
  fleet_t     barcos;
`ifdef REPEAT_SHOT_DETECT_EN
  logic       repeat_shot;
`endif

  modport master (
    output place_valid, place_id, place_row, place_col, place_vert, place_len,
    output shot_valid, shot_row, shot_col,
`ifdef REPEAT_SHOT_DETECT_EN
    input  repeat_shot,
`endif
    input  ready, done, place_err, hit, sunk, sunk_id, all_sunk, barcos
  );

  modport slave (
    input  place_valid, place_id, place_row, place_col, place_vert, place_len,
    input  shot_valid, shot_row, shot_col,
`ifdef REPEAT_SHOT_DETECT_EN
    output repeat_shot,
`endif
    output ready, done, place_err, hit, sunk, sunk_id, all_sunk, barcos
  );
endinterface

// File: rtl/fleet_cell_map.sv
// 25-entry board cell map: combinational read, synchronous write, async clear.
module fleet_cell_map
  import battleship_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rd_addr_i,
  output cell_t      rd_data_o,
  input  logic       we_i,
  input  logic [4:0] wr_addr_i,
  input  cell_t      wr_data_i
);
  cell_t cells_q [NUM_CELLS];

  assign rd_data_o = (rd_addr_i < 5'd25) ? cells_q[rd_addr_i] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        cells_q[i] <= '0;
      end
    end else if (we_i && (wr_addr_i < 5'd25)) begin
      cells_q[wr_addr_i] <= wr_data_i;
    end
  end
endmodule

// File: rtl/fleet_shot_writer.sv
// Places boats on a 5x5 board and applies shots to the fleet damage matrix.
// Define REPEAT_SHOT_DETECT_EN to add shot history and the repeat_shot flag.
module fleet_shot_writer
  import battleship_pkg::*;
#(
  parameter int NUM_BARCOS = 5,
  parameter int BOARD_DIM  = 5
) (
  input logic          clk,
  input logic          rst,
  fleet_shot_writer_if.slave bus
);
  state_t     state_q;
  logic [2:0] idx_q, id_q, row_q, col_q, len_q, tid_q, sunk_id_q;
  logic       vert_q, is_place_q, err_q, hitp_q;
  logic       ready_q, done_q, place_err_q, hit_q, sunk_q, all_sunk_q;
  logic       all_sunk_d;
  fleet_t     barcos_q;
  logic [4:0] placed_q;

  logic [3:0] cur_r_s, cur_c_s;
  logic [4:0] addr_s;
  logic       off_board_s, id_bad_s, len_bad_s, placed_s, pchk_err_s, last_s;
  logic       shot_hit_s, repeat_s;
  cell_t      rd_cell_s, wr_cell_s;

`ifdef REPEAT_SHOT_DETECT_EN
  logic [24:0] hist_q;
  logic        rep_pend_q, repeat_shot_q;
  assign bus.repeat_shot = repeat_shot_q;
`endif

  // Cell under inspection: bow plus idx along the chosen axis; shots use idx 0.
  always_comb begin
    cur_r_s     = {1'b0, row_q} + (vert_q ? {1'b0, idx_q} : 4'd0);
    cur_c_s     = {1'b0, col_q} + (vert_q ? 4'd0 : {1'b0, idx_q});
    off_board_s = (cur_r_s > 4'(BOARD_DIM - 1)) || (cur_c_s > 4'(BOARD_DIM - 1));
    addr_s      = off_board_s ? 5'd0
                : (5'(cur_r_s[2:0]) * 5'(BOARD_DIM) + 5'(cur_c_s[2:0]));
    id_bad_s    = (id_q >= 3'(NUM_BARCOS));
    len_bad_s   = (len_q == 3'd0) || (len_q > 3'(BOARD_DIM));
    placed_s    = id_bad_s ? 1'b0 : placed_q[id_q];
    pchk_err_s  = id_bad_s || len_bad_s || placed_s || off_board_s || rd_cell_s.occ;
    last_s      = (idx_q == (len_q - 3'd1));
`ifdef REPEAT_SHOT_DETECT_EN
    repeat_s    = !off_board_s && hist_q[addr_s];
`else
    repeat_s    = 1'b0;
`endif
    shot_hit_s  = !off_board_s && !repeat_s && rd_cell_s.occ
                  && barcos_q[rd_cell_s.id][rd_cell_s.seg];
    wr_cell_s   = '{occ: 1'b1, id: id_q, seg: idx_q};
    all_sunk_d  = (placed_q != 5'd0);
    for (int j = 0; j < NUM_BARCOS; j++) begin
      all_sunk_d = all_sunk_d && (!placed_q[j] || (barcos_q[j] == 5'd0));
    end
  end

  fleet_cell_map u_map (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_i (addr_s),
    .rd_data_o (rd_cell_s),
    .we_i      (state_q == PWR),
    .wr_addr_i (addr_s),
    .wr_data_i (wr_cell_s)
  );

  // Request sequencing, matrix updates and registered result flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;      ready_q <= 1'b1;     done_q <= 1'b0;
      idx_q <= 3'd0;        id_q <= 3'd0;        row_q <= 3'd0;
      col_q <= 3'd0;        len_q <= 3'd0;       vert_q <= 1'b0;
      is_place_q <= 1'b0;   err_q <= 1'b0;       hitp_q <= 1'b0;
      tid_q <= NO_BOAT;     place_err_q <= 1'b0; hit_q <= 1'b0;
      sunk_q <= 1'b0;       sunk_id_q <= 3'd0;   all_sunk_q <= 1'b0;
      barcos_q <= '0;       placed_q <= 5'd0;
`ifdef REPEAT_SHOT_DETECT_EN
      hist_q <= 25'd0;      rep_pend_q <= 1'b0;  repeat_shot_q <= 1'b0;
`endif
    end else begin
      done_q     <= 1'b0;
      all_sunk_q <= all_sunk_d;
      case (state_q)
        IDLE: begin
          if (bus.place_valid) begin
            id_q <= bus.place_id;   row_q <= bus.place_row; col_q <= bus.place_col;
            vert_q <= bus.place_vert; len_q <= bus.place_len;
            idx_q <= 3'd0; is_place_q <= 1'b1; err_q <= 1'b0;
            state_q <= PCHK; ready_q <= 1'b0;
          end else if (bus.shot_valid) begin
            row_q <= bus.shot_row; col_q <= bus.shot_col; vert_q <= 1'b0;
            idx_q <= 3'd0; is_place_q <= 1'b0;
            state_q <= SHOT; ready_q <= 1'b0;
          end
        end
        PCHK: begin
          if (pchk_err_s) begin
            err_q <= 1'b1; state_q <= DONE;
          end else if (last_s) begin
            idx_q <= 3'd0; state_q <= PWR;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        PWR: begin
          if (last_s) begin
            barcos_q[id_q] <= len_mask(len_q);
            placed_q[id_q] <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        SHOT: begin
          hitp_q <= shot_hit_s;
          tid_q  <= shot_hit_s ? rd_cell_s.id : NO_BOAT;
          if (shot_hit_s) begin
            barcos_q[rd_cell_s.id][rd_cell_s.seg] <= 1'b0;
          end
`ifdef REPEAT_SHOT_DETECT_EN
          rep_pend_q <= repeat_s;
          if (!off_board_s && !repeat_s) begin
            hist_q[addr_s] <= 1'b1;
          end
`endif
          state_q <= DONE;
        end
        DONE: begin
          done_q <= 1'b1;
          if (is_place_q) begin
            place_err_q <= err_q; hit_q <= 1'b0; sunk_q <= 1'b0; sunk_id_q <= 3'd0;
`ifdef REPEAT_SHOT_DETECT_EN
            repeat_shot_q <= 1'b0;
`endif
          end else begin
            place_err_q <= 1'b0;
            hit_q       <= hitp_q;
            sunk_q      <= hitp_q && (barcos_q[tid_q] == 5'd0);
            sunk_id_q   <= (hitp_q && (barcos_q[tid_q] == 5'd0)) ? tid_q : 3'd0;
`ifdef REPEAT_SHOT_DETECT_EN
            repeat_shot_q <= rep_pend_q;
`endif
          end
          state_q <= IDLE; ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE; ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.place_err = place_err_q;
  assign bus.hit       = hit_q;
  assign bus.sunk      = sunk_q;
  assign bus.sunk_id   = sunk_id_q;
  assign bus.all_sunk  = all_sunk_q;
  assign bus.barcos    = barcos_q;
endmodule

// File: tb/tb_fleet_shot_writer.sv
// Directed bench for fleet_shot_writer: placements, rejects, shots, priority, mid-op reset.
module tb_fleet_shot_writer;
  import battleship_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   lat;

  always #5 clk = ~clk;

  fleet_shot_writer_if bus ();

  fleet_shot_writer #(.NUM_BARCOS(5), .BOARD_DIM(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycles from the acceptance edge to done, bounded at 40.
  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic place(input logic [2:0] id, input logic [2:0] r, input logic [2:0] c,
                       input logic v, input logic [2:0] len, output int n);
    bus.place_id = id; bus.place_row = r; bus.place_col = c;
    bus.place_vert = v; bus.place_len = len; bus.place_valid = 1'b1;
    @(posedge clk); #1;
    bus.place_valid = 1'b0;
    wait_done(n);
  endtask

  task automatic shot(input logic [2:0] r, input logic [2:0] c, output int n);
    bus.shot_row = r; bus.shot_col = c; bus.shot_valid = 1'b1;
    @(posedge clk); #1;
    bus.shot_valid = 1'b0;
    wait_done(n);
  endtask

  initial begin
    bus.place_valid = 1'b0; bus.place_id = 3'd0; bus.place_row = 3'd0;
    bus.place_col = 3'd0; bus.place_vert = 1'b0; bus.place_len = 3'd0;
    bus.shot_valid = 1'b0; bus.shot_row = 3'd0; bus.shot_col = 3'd0;

    #12;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_barcos", 32'(bus.barcos), 32'd0);
    chk("rst_flags", {28'd0, bus.place_err, bus.hit, bus.sunk, bus.all_sunk}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    place(3'd0, 3'd1, 3'd1, 1'b0, 3'd3, lat);
    chk("p0_lat", 32'(lat), 32'd7);
    chk("p0_barcos", 32'(bus.barcos), 32'h7);
    chk("p0_err", 32'(bus.place_err), 32'd0);

    place(3'd1, 3'd1, 3'd2, 1'b1, 3'd2, lat);
    chk("ovl_lat", 32'(lat), 32'd2);
    chk("ovl_err", 32'(bus.place_err), 32'd1);
    chk("ovl_barcos", 32'(bus.barcos), 32'h7);

    shot(3'd4, 3'd4, lat);
    chk("empty_lat", 32'(lat), 32'd2);
    chk("empty_hit", 32'(bus.hit), 32'd0);
    chk("empty_err_clr", 32'(bus.place_err), 32'd0);
    shot(3'd7, 3'd0, lat);
    chk("off_lat", 32'(lat), 32'd2);
    chk("off_hit", 32'(bus.hit), 32'd0);
    chk("off_barcos", 32'(bus.barcos), 32'h7);

    shot(3'd1, 3'd1, lat);
    chk("s11", {29'd0, bus.hit, bus.sunk, 1'b0}, 32'b100);
    chk("s11_barcos", 32'(bus.barcos), 32'h6);
    shot(3'd1, 3'd2, lat);
    chk("s12", {29'd0, bus.hit, bus.sunk, 1'b0}, 32'b100);
    shot(3'd1, 3'd3, lat);
    chk("s13", {29'd0, bus.hit, bus.sunk, 1'b0}, 32'b110);
    chk("s13_sunk_id", 32'(bus.sunk_id), 32'd0);
    chk("s13_barcos", 32'(bus.barcos), 32'h0);
    @(posedge clk); #1;
    chk("all_sunk_1", 32'(bus.all_sunk), 32'd1);

    // Placement and shot requested together: placement wins, shot is held.
    bus.place_id = 3'd2; bus.place_row = 3'd3; bus.place_col = 3'd0;
    bus.place_vert = 1'b0; bus.place_len = 3'd2; bus.place_valid = 1'b1;
    bus.shot_row = 3'd3; bus.shot_col = 3'd1; bus.shot_valid = 1'b1;
    @(posedge clk); #1;
    bus.place_valid = 1'b0;
    chk("prio_busy", 32'(bus.ready), 32'd0);
    wait_done(lat);
    chk("prio_place_lat", 32'(lat), 32'd5);
    chk("prio_barcos", 32'(bus.barcos), 32'hC00);
    chk("prio_hit_clr", {30'd0, bus.hit, bus.sunk}, 32'd0);
    chk("prio_all_sunk", 32'(bus.all_sunk), 32'd0);
    @(posedge clk); #1;
    bus.shot_valid = 1'b0;
    wait_done(lat);
    chk("prio_shot_lat", 32'(lat), 32'd2);
    chk("prio_shot_hit", 32'(bus.hit), 32'd1);
    chk("prio_shot_barcos", 32'(bus.barcos), 32'h400);

    shot(3'd3, 3'd0, lat);
    chk("s30", {29'd0, bus.hit, bus.sunk, 1'b0}, 32'b110);
    chk("s30_sunk_id", 32'(bus.sunk_id), 32'd2);
`ifdef REPEAT_SHOT_DETECT_EN
    chk("s30_repeat", 32'(bus.repeat_shot), 32'd0);
`endif
    @(posedge clk); #1;
    chk("all_sunk_2", 32'(bus.all_sunk), 32'd1);

    place(3'd5, 3'd0, 3'd0, 1'b0, 3'd1, lat);
    chk("badid_lat", 32'(lat), 32'd2);
    chk("badid_err", 32'(bus.place_err), 32'd1);
    chk("badid_hit_clr", {30'd0, bus.hit, bus.sunk}, 32'd0);
    place(3'd3, 3'd0, 3'd0, 1'b0, 3'd0, lat);
    chk("len0_err", 32'(bus.place_err), 32'd1);
    place(3'd3, 3'd0, 3'd0, 1'b0, 3'd6, lat);
    chk("len6_err", 32'(bus.place_err), 32'd1);
    place(3'd0, 3'd0, 3'd0, 1'b0, 3'd1, lat);
    chk("dup_err", 32'(bus.place_err), 32'd1);
    place(3'd3, 3'd4, 3'd3, 1'b0, 3'd3, lat);
    chk("edge_lat", 32'(lat), 32'd4);
    chk("edge_err", 32'(bus.place_err), 32'd1);
    chk("rej_barcos", 32'(bus.barcos), 32'h0);

    place(3'd3, 3'd0, 3'd4, 1'b1, 3'd5, lat);
    chk("p3_lat", 32'(lat), 32'd11);
    chk("p3_err", 32'(bus.place_err), 32'd0);
    chk("p3_barcos", 32'(bus.barcos), 32'hF8000);
    @(posedge clk); #1;
    chk("p3_all_sunk", 32'(bus.all_sunk), 32'd0);

    shot(3'd1, 3'd1, lat);
    chk("rep_hit", 32'(bus.hit), 32'd0);
    chk("rep_barcos", 32'(bus.barcos), 32'hF8000);
`ifdef REPEAT_SHOT_DETECT_EN
    chk("rep_flag", 32'(bus.repeat_shot), 32'd1);
`endif

    // Reset while the len-4 placement is in its write phase.
    bus.place_id = 3'd4; bus.place_row = 3'd0; bus.place_col = 3'd0;
    bus.place_vert = 1'b0; bus.place_len = 3'd4; bus.place_valid = 1'b1;
    @(posedge clk); #1;
    bus.place_valid = 1'b0;
    repeat (6) begin
      @(posedge clk);
    end
    #1;
    rst = 1'b0;
    #2;
    chk("mid_rst_barcos", 32'(bus.barcos), 32'h0);
    chk("mid_rst_ready", 32'(bus.ready), 32'd1);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(bus.ready), 32'd1);

    place(3'd0, 3'd1, 3'd1, 1'b0, 3'd3, lat);
    chk("re_p0_lat", 32'(lat), 32'd7);
    chk("re_p0_err", 32'(bus.place_err), 32'd0);
    place(3'd4, 3'd0, 3'd0, 1'b0, 3'd4, lat);
    chk("re_p4_lat", 32'(lat), 32'd9);
    chk("re_p4_err", 32'(bus.place_err), 32'd0);
    chk("re_barcos", 32'(bus.barcos), 32'hF00007);

    shot(3'd1, 3'd1, lat);
    chk("re_s11_hit", 32'(bus.hit), 32'd1);
`ifdef REPEAT_SHOT_DETECT_EN
    chk("re_s11_repeat", 32'(bus.repeat_shot), 32'd0);
`endif
    shot(3'd1, 3'd1, lat);
    chk("re_s11b_hit", {30'd0, bus.hit, bus.sunk}, 32'd0);
    chk("re_s11b_barcos", 32'(bus.barcos), 32'hF00006);
`ifdef REPEAT_SHOT_DETECT_EN
    chk("re_s11b_repeat", 32'(bus.repeat_shot), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
